// File: rtl/uart_frame_packer.sv
// uart_frame_packer: snapshots N_CH channel words on a frame tick and streams them as UART bytes.
// Ports:
//   clk_i           system clock (65 MHz pixel clock)
//   rst_ni          asynchronous reset, active low
//   frame_start_i   single-cycle frame tick
//   ch_data_i       flattened channels, ch k = ch_data_i[k*W +: W]
//   tx_data_o       byte offered to the uart transmitter
//   tx_valid_o      tx_data_o valid
//   tx_ready_i      transmitter accepts the byte
//   busy_o          frame in progress
//   frame_done_o    one-cycle pulse after the last byte is accepted
//   overrun_cnt_o   saturating count of frame ticks dropped while busy
// Frame: SYNC_BYTE, then per channel high byte and low byte of the zero-extended word.
// Define FRAME_CHECKSUM_EN to append an XOR-of-payload checksum byte.
module uart_frame_packer #(
    parameter int         N_CH      = 4,
    parameter int         W         = 12,
    parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              frame_start_i,
    input  logic [N_CH*W-1:0] ch_data_i,
    output logic [7:0]        tx_data_o,
    output logic              tx_valid_o,
    input  logic              tx_ready_i,
    output logic              busy_o,
    output logic              frame_done_o,
    output logic [7:0]        overrun_cnt_o
);
    localparam int CW = (N_CH > 1) ? $clog2(N_CH) : 1;

    if (N_CH < 1 || W < 1 || W > 16) begin : g_param_check
        $error("uart_frame_packer: requires N_CH >= 1 and 1 <= W <= 16");
    end

    typedef enum logic [2:0] {
        IDLE, SYNC, HI, LO
`ifdef FRAME_CHECKSUM_EN
        , CSUM
`endif
    } state_t;

    state_t          state_q;
    logic [CW-1:0]   ch_q;
    logic [W-1:0]    snap_q [N_CH];
    logic [7:0]      tx_data_q;
    logic            tx_valid_q;
    logic            busy_q;
    logic            frame_done_q;
    logic [7:0]      overrun_q;
`ifdef FRAME_CHECKSUM_EN
    logic [7:0]      csum_q;
`endif

    logic            xfer;
    logic            last_ch;
    logic [CW-1:0]   ch_nxt;

    assign xfer    = tx_valid_q && tx_ready_i;
    assign last_ch = ch_q == CW'(N_CH - 1);
    // Saturate at the last channel so the look-ahead index never leaves the array.
    assign ch_nxt  = last_ch ? ch_q : ch_q + 1'b1;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            ch_q         <= '0;
            tx_data_q    <= '0;
            tx_valid_q   <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            overrun_q    <= '0;
`ifdef FRAME_CHECKSUM_EN
            csum_q       <= '0;
`endif
            for (int i = 0; i < N_CH; i++) snap_q[i] <= '0;
        end else begin
            frame_done_q <= 1'b0;
            if (frame_start_i && state_q != IDLE && overrun_q != 8'hFF) overrun_q <= overrun_q + 8'd1;
            case (state_q)
                IDLE: if (frame_start_i) begin
                    for (int i = 0; i < N_CH; i++) snap_q[i] <= ch_data_i[i*W +: W];
`ifdef FRAME_CHECKSUM_EN
                    csum_q     <= '0;
`endif
                    tx_data_q  <= SYNC_BYTE;
                    tx_valid_q <= 1'b1;
                    busy_q     <= 1'b1;
                    state_q    <= SYNC;
                end
                SYNC: if (xfer) begin
                    ch_q      <= '0;
                    tx_data_q <= 8'(16'(snap_q[0]) >> 8);
                    state_q   <= HI;
                end
                HI: if (xfer) begin
`ifdef FRAME_CHECKSUM_EN
                    csum_q    <= csum_q ^ tx_data_q;
`endif
                    tx_data_q <= 8'(16'(snap_q[ch_q]));
                    state_q   <= LO;
                end
                LO: if (xfer) begin
`ifdef FRAME_CHECKSUM_EN
                    csum_q <= csum_q ^ tx_data_q;
`endif
                    if (!last_ch) begin
                        ch_q      <= ch_nxt;
                        tx_data_q <= 8'(16'(snap_q[ch_nxt]) >> 8);
                        state_q   <= HI;
                    end else begin
`ifdef FRAME_CHECKSUM_EN
                        // The byte just accepted is folded in directly; csum_q lags by one.
                        tx_data_q <= csum_q ^ tx_data_q;
                        state_q   <= CSUM;
`else
                        tx_data_q    <= '0;
                        tx_valid_q   <= 1'b0;
                        busy_q       <= 1'b0;
                        frame_done_q <= 1'b1;
                        state_q      <= IDLE;
`endif
                    end
                end
`ifdef FRAME_CHECKSUM_EN
                CSUM: if (xfer) begin
                    tx_data_q    <= '0;
                    tx_valid_q   <= 1'b0;
                    busy_q       <= 1'b0;
                    frame_done_q <= 1'b1;
                    state_q      <= IDLE;
                end
`endif
                default: state_q <= IDLE;
            endcase
        end
    end

    assign tx_data_o     = tx_data_q;
    assign tx_valid_o    = tx_valid_q;
    assign busy_o        = busy_q;
    assign frame_done_o  = frame_done_q;
    assign overrun_cnt_o = overrun_q;
endmodule

// File: tb/tb_uart_frame_packer.sv
// tb_uart_frame_packer: directed self-checking bench for uart_frame_packer.
module tb_uart_frame_packer;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        fs, ready;
    logic [23:0] ch_data;
    logic [7:0]  tx_data, ovr;
    logic        tx_valid, busy, done;
    logic        fs2, ready2;
    logic [15:0] ch2;
    logic [7:0]  tx_data2, ovr2;
    logic        tx_valid2, busy2, done2;
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    uart_frame_packer #(.N_CH(2), .W(12)) dut (
        .clk_i(clk), .rst_ni(rst_n), .frame_start_i(fs), .ch_data_i(ch_data),
        .tx_data_o(tx_data), .tx_valid_o(tx_valid), .tx_ready_i(ready),
        .busy_o(busy), .frame_done_o(done), .overrun_cnt_o(ovr)
    );

    uart_frame_packer #(.N_CH(1), .W(16)) dut2 (
        .clk_i(clk), .rst_ni(rst_n), .frame_start_i(fs2), .ch_data_i(ch2),
        .tx_data_o(tx_data2), .tx_valid_o(tx_valid2), .tx_ready_i(ready2),
        .busy_o(busy2), .frame_done_o(done2), .overrun_cnt_o(ovr2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic byte_chk(input string tag, input logic [7:0] b);
        @(negedge clk);
        chk({tag, "_valid"}, 32'(tx_valid), 32'd1);
        chk({tag, "_data"}, 32'(tx_data), 32'(b));
        chk({tag, "_nodone"}, 32'(done), 32'd0);
    endtask

    task automatic byte_chk2(input string tag, input logic [7:0] b);
        @(negedge clk);
        chk({tag, "_valid"}, 32'(tx_valid2), 32'd1);
        chk({tag, "_data"}, 32'(tx_data2), 32'(b));
    endtask

    task automatic end_chk(input string tag);
        @(negedge clk);
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_valid"}, 32'(tx_valid), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; fs = 1'b0; ready = 1'b1; ch_data = {12'hABC, 12'h123};
        fs2 = 1'b0; ready2 = 1'b1; ch2 = 16'hBEEF;
        repeat (2) @(negedge clk);
        chk("rst_data", 32'(tx_data), 32'h0);
        chk("rst_valid", 32'(tx_valid), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_ovr", 32'(ovr), 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_valid", 32'(tx_valid), 32'h0);

        // Single frame at full rate, SYNC one cycle after the tick.
        fs = 1'b1;
        @(negedge clk);
        fs = 1'b0;
        chk("f1_sync", 32'(tx_data), 32'hA5);
        chk("f1_sync_valid", 32'(tx_valid), 32'h1);
        chk("f1_busy", 32'(busy), 32'h1);
        byte_chk("f1_b1", 8'h01);
        byte_chk("f1_b2", 8'h23);
        byte_chk("f1_b3", 8'h0A);
        byte_chk("f1_b4", 8'hBC);
`ifdef FRAME_CHECKSUM_EN
        byte_chk("f1_csum", 8'h94);
`endif
        end_chk("f1_end");
        // Tick in the frame_done cycle must start a new frame.
        fs = 1'b1;
        @(negedge clk);
        fs = 1'b0;
        chk("f2_done_once", 32'(done), 32'h0);
        chk("f2_sync", 32'(tx_data), 32'hA5);
        chk("f2_ovr", 32'(ovr), 32'h0);
        ch_data[11:0] = 12'hFFF;
        byte_chk("f2_b1", 8'h01);
        byte_chk("f2_b2", 8'h23);
        ready = 1'b0;
        for (int i = 0; i < 3; i++) byte_chk("f2_stall", 8'h23);
        ready = 1'b1;
        byte_chk("f2_b3", 8'h0A);
        byte_chk("f2_b4", 8'hBC);
`ifdef FRAME_CHECKSUM_EN
        byte_chk("f2_csum", 8'h94);
`endif
        end_chk("f2_end");

        // Overrun saturation with the transmitter stalled.
        ch_data = {12'hABC, 12'h123};
        ready = 1'b0;
        fs = 1'b1;
        @(negedge clk);
        ch_data = 24'h0;
        repeat (300) @(negedge clk);
        fs = 1'b0;
        chk("ovr_sat", 32'(ovr), 32'hFF);
        chk("ovr_hold_data", 32'(tx_data), 32'hA5);
        chk("ovr_hold_valid", 32'(tx_valid), 32'h1);
        ready = 1'b1;
        byte_chk("f3_b1", 8'h01);
        byte_chk("f3_b2", 8'h23);
        byte_chk("f3_b3", 8'h0A);
        byte_chk("f3_b4", 8'hBC);
`ifdef FRAME_CHECKSUM_EN
        byte_chk("f3_csum", 8'h94);
`endif
        end_chk("f3_end");
        chk("ovr_kept", 32'(ovr), 32'hFF);

        // Asynchronous reset while the low byte is offered.
        ch_data = {12'hABC, 12'h123};
        fs = 1'b1;
        @(negedge clk);
        fs = 1'b0;
        byte_chk("f4_b1", 8'h01);
        byte_chk("f4_b2", 8'h23);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_data", 32'(tx_data), 32'h0);
        chk("arst_valid", 32'(tx_valid), 32'h0);
        chk("arst_busy", 32'(busy), 32'h0);
        chk("arst_done", 32'(done), 32'h0);
        chk("arst_ovr", 32'(ovr), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("post_rst_valid", 32'(tx_valid), 32'h0);
            chk("post_rst_busy", 32'(busy), 32'h0);
        end

        // Single 16-bit channel.
        fs2 = 1'b1;
        @(negedge clk);
        fs2 = 1'b0;
        chk("w16_sync", 32'(tx_data2), 32'hA5);
        byte_chk2("w16_hi", 8'hBE);
        byte_chk2("w16_lo", 8'hEF);
`ifdef FRAME_CHECKSUM_EN
        byte_chk2("w16_csum", 8'h51);
`endif
        @(negedge clk);
        chk("w16_done", 32'(done2), 32'h1);
        chk("w16_valid_end", 32'(tx_valid2), 32'h0);
        chk("w16_ovr", 32'(ovr2), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
